// File: rtl/snn_spike_counter_pkg.sv
// Shared FSM state encoding and default sizing for the SNN spike counter.
// Imported by the counter top level.
package snn_spike_counter_pkg;

  localparam int SPIKE_W_DEF     = 250;
  localparam int NUM_CLASSES_DEF = 10;
  localparam int CNT_W_DEF       = 16;
  localparam int CLS_W_DEF       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/snn_spike_counter_popcount.sv
// Combinational population count of one class's spike group.
// A single instance serves every class through the index mux in the top.
module snn_spike_counter_popcount #(
  parameter int W   = 25,
  parameter int PCW = $clog2(W + 1)
) (
  input  logic [W-1:0]   bits_i,
  output logic [PCW-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + PCW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/snn_spike_counter.sv
// Per-class spike accumulator with serial argmax for the SNN output layer.
// Sums spike popcounts per class over an image, then reports the winning class.
module snn_spike_counter
  import snn_spike_counter_pkg::*;
#(
  parameter int SPIKE_W     = SPIKE_W_DEF,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int CLS_W       = CLS_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_ready,
  input  logic               complete,
  input  logic [SPIKE_W-1:0] spike_out,
  input  logic               clear,
  input  logic [CLS_W-1:0]   cnt_rd_idx,
  output logic [CNT_W-1:0]   cnt_rd_data,
  output logic               busy,
  output logic               result_valid,
  output logic [CLS_W-1:0]   result_class,
  output logic [CNT_W-1:0]   result_max,
  output logic               overflow,
  output logic               tick_overrun
);

  localparam int GRP  = SPIKE_W / NUM_CLASSES;
  localparam int PC_W = $clog2(GRP + 1);
  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);
  localparam logic [CLS_W-1:0] FIN_IDX  = CLS_W'(NUM_CLASSES);

  function automatic logic [CNT_W:0] add_wide(input logic [CNT_W-1:0] a,
                                              input logic [PC_W-1:0]  b);
    return {1'b0, a} + {{(CNT_W + 1 - PC_W){1'b0}}, b};
  endfunction

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W:0] s);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  state_e             state_q, state_d;
  logic [CLS_W-1:0]   idx_q, idx_d;
  logic [SPIKE_W-1:0] spk_q;
  logic [CNT_W-1:0]   cnt_q [NUM_CLASSES];
  logic               tick_prev_q, cmp_prev_q;
  logic               cmp_pend_q, cmp_pend_d;
  logic [CNT_W-1:0]   best_q, best_d;
  logic [CLS_W-1:0]   best_idx_q, best_idx_d;
  logic               res_valid_q, res_valid_d;
  logic [CLS_W-1:0]   res_class_q, res_class_d;
  logic [CNT_W-1:0]   res_max_q, res_max_d;
  logic               overflow_q, overflow_d;
  logic               overrun_q, overrun_d;
  logic               spk_load, cnt_we;
  logic               tick_rise, cmp_rise;
  logic [CLS_W-1:0]   sel;
  logic [GRP-1:0]     grp_bits;
  logic [PC_W-1:0]    pop;
  logic [CNT_W-1:0]   cur_cnt;
  logic [CNT_W:0]     acc_sum;

  assign tick_rise = tick_ready & ~tick_prev_q;
  assign cmp_rise  = complete & ~cmp_prev_q;

  // idx runs one past the last class during the argmax finalize cycle
  assign sel      = (idx_q < FIN_IDX) ? idx_q : '0;
  assign grp_bits = spk_q[int'(sel)*GRP +: GRP];
  assign cur_cnt  = cnt_q[sel];
  assign acc_sum  = add_wide(cur_cnt, pop);

  snn_spike_counter_popcount #(.W(GRP), .PCW(PC_W)) u_popcount (
    .bits_i  (grp_bits),
    .count_o (pop)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cmp_pend_d  = cmp_pend_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    res_max_d   = res_max_q;
    overflow_d  = overflow_q;
    overrun_d   = overrun_q;
    spk_load    = 1'b0;
    cnt_we      = 1'b0;
    if (clear) begin
      state_d     = IDLE;
      idx_d       = '0;
      cmp_pend_d  = 1'b0;
      best_d      = '0;
      best_idx_d  = '0;
      res_valid_d = 1'b0;
      res_class_d = '0;
      res_max_d   = '0;
      overflow_d  = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick_rise) begin
            spk_load   = 1'b1;
            idx_d      = '0;
            state_d    = ACCUM;
            cmp_pend_d = cmp_pend_q | cmp_rise;
          end else if (cmp_rise) begin
            idx_d      = '0;
            best_d     = '0;
            best_idx_d = '0;
            state_d    = ARGMAX;
          end
        end
        ACCUM: begin
          cnt_we = 1'b1;
          if (acc_sum[CNT_W]) overflow_d = 1'b1;
          if (tick_rise)      overrun_d  = 1'b1;
          if (cmp_rise)       cmp_pend_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (cmp_pend_q | cmp_rise) begin
              cmp_pend_d = 1'b0;
              best_d     = '0;
              best_idx_d = '0;
              state_d    = ARGMAX;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ARGMAX: begin
          if (idx_q == FIN_IDX) begin
            res_valid_d = 1'b1;
            res_class_d = best_idx_q;
            res_max_d   = best_q;
            idx_d       = '0;
            state_d     = DONE;
          end else begin
            // strict compare keeps the lowest index on ties
            if (cur_cnt > best_q) begin
              best_d     = cur_cnt;
              best_idx_d = idx_q;
            end
            idx_d = idx_q + 1'b1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tick_prev_q <= 1'b1;
      cmp_prev_q  <= 1'b1;
      cmp_pend_q  <= 1'b0;
      best_q      <= '0;
      best_idx_q  <= '0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_max_q   <= '0;
      overflow_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tick_prev_q <= tick_ready;
      cmp_prev_q  <= complete;
      cmp_pend_q  <= cmp_pend_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_max_q   <= res_max_d;
      overflow_q  <= overflow_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
    end else if (cnt_we) begin
      cnt_q[idx_q] <= sat(acc_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (spk_load) spk_q <= spike_out;
  end

  assign cnt_rd_data  = (cnt_rd_idx < FIN_IDX) ? cnt_q[cnt_rd_idx] : '0;
  assign busy         = (state_q == ACCUM) || (state_q == ARGMAX);
  assign result_valid = res_valid_q;
  assign result_class = res_class_q;
  assign result_max   = res_max_q;
  assign overflow     = overflow_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_snn_spike_counter.sv
// Directed bench for snn_spike_counter: a default build plus an 8-bit-counter
// build sharing the same stimulus, checked with immediate assertions.
module tb_snn_spike_counter;

  localparam int SW  = 250;
  localparam int GRP = 25;

  logic          clk = 1'b0;
  logic          reset, tick_ready, complete, clear;
  logic [SW-1:0] spike_out;
  logic [3:0]    cnt_rd_idx;

  logic [15:0] cnt16, max16;
  logic        busy16, valid16, ov16, orun16;
  logic [3:0]  cls16;
  logic [7:0]  cnt8, max8;
  logic        busy8, valid8, ov8, orun8;
  logic [3:0]  cls8;

  int total = 0;
  int bad   = 0;
  int busy_cycles;

  always #5 clk = ~clk;

  snn_spike_counter dut (
    .clk(clk), .reset(reset), .tick_ready(tick_ready), .complete(complete),
    .spike_out(spike_out), .clear(clear), .cnt_rd_idx(cnt_rd_idx),
    .cnt_rd_data(cnt16), .busy(busy16), .result_valid(valid16),
    .result_class(cls16), .result_max(max16), .overflow(ov16),
    .tick_overrun(orun16)
  );

  snn_spike_counter #(.CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .tick_ready(tick_ready), .complete(complete),
    .spike_out(spike_out), .clear(clear), .cnt_rd_idx(cnt_rd_idx),
    .cnt_rd_data(cnt8), .busy(busy8), .result_valid(valid8),
    .result_class(cls8), .result_max(max8), .overflow(ov8),
    .tick_overrun(orun8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] ones(input int cls, input int n);
    logic [SW-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[cls*GRP + i] = 1'b1;
    return v;
  endfunction

  task automatic tick(input logic [SW-1:0] v);
    spike_out  = v;
    tick_ready = 1'b1;
    step(1);
    tick_ready = 1'b0;
    step(10);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic rd(input int idx);
    cnt_rd_idx = 4'(idx);
    step(1);
  endtask

  initial begin
    reset = 1'b1; tick_ready = 1'b0; complete = 1'b0; clear = 1'b0;
    spike_out = '0; cnt_rd_idx = '0;
    step(3);
    reset = 1'b0;
    step(1);
    chk("rst_busy",  32'(busy16),  0);
    chk("rst_valid", 32'(valid16), 0);
    chk("rst_class", 32'(cls16),   0);
    chk("rst_max",   32'(max16),   0);
    chk("rst_ovf",   32'(ov16),    0);
    chk("rst_orun",  32'(orun16),  0);
    chk("rst_cnt0",  32'(cnt16),   0);

    // single tick, class 0 fully spiking
    spike_out  = ones(0, 25);
    tick_ready = 1'b1;
    step(1);
    tick_ready  = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy16) busy_cycles++;
      step(1);
    end
    chk("t1_busy_cycles", 32'(busy_cycles), 10);
    rd(0);
    chk("t1_cnt0", 32'(cnt16), 25);
    for (int c = 1; c < 10; c++) begin
      rd(c);
      chk("t1_cnt_other", 32'(cnt16), 0);
    end

    // three ticks then complete: class 3 wins 15 over 12
    pulse_clear();
    for (int k = 0; k < 3; k++) tick(ones(3, 5) | ones(7, 4));
    complete = 1'b1;
    step(1);
    complete = 1'b0;
    chk("t2_busy_argmax", 32'(busy16), 1);
    step(10);
    chk("t2_valid_early", 32'(valid16), 0);
    step(1);
    chk("t2_valid", 32'(valid16), 1);
    chk("t2_class", 32'(cls16),   3);
    chk("t2_max",   32'(max16),   15);
    chk("t2_busy",  32'(busy16),  0);
    rd(3);  chk("t2_cnt3",  32'(cnt16), 15);
    rd(7);  chk("t2_cnt7",  32'(cnt16), 12);
    rd(12); chk("t2_cnt_oob", 32'(cnt16), 0);
    tick(ones(3, 5));
    chk("t2_done_valid", 32'(valid16), 1);
    chk("t2_done_busy",  32'(busy16),  0);
    rd(3);  chk("t2_done_cnt3", 32'(cnt16), 15);

    // tie with simultaneous tick+complete in IDLE
    pulse_clear();
    chk("t3_clear_valid", 32'(valid16), 0);
    spike_out  = ones(2, 12) | ones(6, 12);
    tick_ready = 1'b1;
    complete   = 1'b1;
    step(1);
    tick_ready = 1'b0;
    complete   = 1'b0;
    step(20);
    chk("t3_valid_early", 32'(valid16), 0);
    step(1);
    chk("t3_valid", 32'(valid16), 1);
    chk("t3_class", 32'(cls16),   2);
    chk("t3_max",   32'(max16),   12);

    // saturation on the 8-bit build
    pulse_clear();
    for (int k = 0; k < 10; k++) tick(ones(1, 25));
    rd(1);
    chk("t4_cnt8_250", 32'(cnt8), 250);
    chk("t4_ovf8_pre", 32'(ov8),  0);
    tick(ones(1, 10));
    rd(1);
    chk("t4_cnt8_sat", 32'(cnt8),  255);
    chk("t4_ovf8",     32'(ov8),   1);
    chk("t4_cnt16",    32'(cnt16), 260);
    chk("t4_ovf16",    32'(ov16),  0);
    tick(ones(1, 1));
    rd(1);
    chk("t4_cnt8_hold", 32'(cnt8), 255);
    chk("t4_ovf8_sticky", 32'(ov8), 1);
    pulse_clear();
    chk("t4_ovf8_clr", 32'(ov8), 0);
    rd(1);
    chk("t4_cnt8_clr", 32'(cnt8), 0);

    // overrun tick dropped, complete pended during ACCUM
    pulse_clear();
    spike_out  = ones(5, 3);
    tick_ready = 1'b1;
    step(1);
    tick_ready = 1'b0;
    step(2);
    spike_out  = ones(5, 25);
    tick_ready = 1'b1;
    step(1);
    tick_ready = 1'b0;
    chk("t5_overrun", 32'(orun16), 1);
    complete = 1'b1;
    step(1);
    complete = 1'b0;
    step(16);
    chk("t5_valid_early", 32'(valid16), 0);
    step(1);
    chk("t5_valid", 32'(valid16), 1);
    chk("t5_class", 32'(cls16),   5);
    chk("t5_max",   32'(max16),   3);
    chk("t5_overrun_sticky", 32'(orun16), 1);
    rd(5); chk("t5_cnt5", 32'(cnt16), 3);

    // clear aborts ARGMAX; clear drops a same-cycle tick; tick high at reset release
    pulse_clear();
    chk("t6_orun_clr", 32'(orun16), 0);
    tick(ones(4, 7));
    complete = 1'b1;
    step(1);
    complete = 1'b0;
    step(3);
    chk("t6_busy_mid", 32'(busy16), 1);
    pulse_clear();
    chk("t6_busy_abort",  32'(busy16),  0);
    chk("t6_valid_abort", 32'(valid16), 0);
    step(15);
    chk("t6_valid_later", 32'(valid16), 0);
    rd(4); chk("t6_cnt4", 32'(cnt16), 0);
    spike_out  = ones(0, 25);
    clear      = 1'b1;
    tick_ready = 1'b1;
    step(1);
    clear = 1'b0;
    chk("t6_clear_tick_busy", 32'(busy16), 0);
    tick_ready = 1'b0;
    step(2);
    tick_ready = 1'b1;
    reset      = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
    chk("t6_rst_tick_busy", 32'(busy16), 0);
    rd(0); chk("t6_rst_tick_cnt0", 32'(cnt16), 0);
    tick_ready = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
